// File: rtl/seg_scan_demux.sv
// Four-digit seven-segment scan driver. Each digit owns a slot of
// REFRESH_DIV cycles: anodes stay off for the first BLANK_CYC cycles
// (ghosting guard), then the digit latched at the slot start is driven.
module seg_scan_demux #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_CYC   = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        en,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blank,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [1:0]  digit_idx
);

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

   typedef enum logic {PH_BLANK = 1'b0, PH_DRIVE = 1'b1} phase_e;
   // Phase that matches cnt=0 straight out of reset.
   localparam phase_e PH_RST = (BLANK_CYC == 0) ? PH_DRIVE : PH_BLANK;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   phase_e        phase_q, phase_d;
   logic [3:0]    snap_nib_q;
   logic          snap_dp_q, snap_blk_q;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic [1:0]    didx_q;

   logic [3:0]    live_nib, cur_nib;
   logic          live_dp, live_blk, cur_dp, cur_blk, slot_start;

   // Standard active-low hex decode, {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      hex7 = 7'h7F;
      case (n)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         4'hF: hex7 = 7'h0E;
         default: hex7 = 7'h7F;
      endcase
   endfunction

   // At slot start the live inputs are the snapshot being taken, so they
   // feed the output path directly (matters only when BLANK_CYC is 0).
   assign slot_start = (cnt_q == '0);
   assign live_nib   = digits[{idx_q, 2'b00} +: 4];
   assign live_dp    = dp_in[idx_q];
   assign live_blk   = blank[idx_q];
   assign cur_nib    = slot_start ? live_nib : snap_nib_q;
   assign cur_dp     = slot_start ? live_dp  : snap_dp_q;
   assign cur_blk    = slot_start ? live_blk : snap_blk_q;

   // Slot counter and digit index advance, held while en is low.
   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (en) begin
         if (cnt_q == LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Phase FSM next state: tracks whether the upcoming cnt is in the guard.
   always_comb begin
      phase_d = PH_DRIVE;
      if (int'(cnt_d) < BLANK_CYC) phase_d = PH_BLANK;
   end

   // Output selection for the current cnt/idx; everything dark unless driving.
   always_comb begin
      an_d  = 4'hF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (en && phase_q == PH_DRIVE && !cur_blk) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = hex7(cur_nib);
         dp_d  = ~cur_dp;
      end
   end

   // Scan state, phase register and slot-start snapshot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q      <= '0;
         idx_q      <= 2'd0;
         phase_q    <= PH_RST;
         snap_nib_q <= 4'h0;
         snap_dp_q  <= 1'b0;
         snap_blk_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         phase_q <= phase_d;
         if (en && slot_start) begin
            snap_nib_q <= live_nib;
            snap_dp_q  <= live_dp;
            snap_blk_q <= live_blk;
         end
      end
   end

   // Registered pin drivers, one cycle behind the state that selects them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         an_q   <= 4'hF;
         seg_q  <= 7'h7F;
         dp_q   <= 1'b1;
         didx_q <= 2'd0;
      end else begin
         an_q   <= an_d;
         seg_q  <= seg_d;
         dp_q   <= dp_d;
         didx_q <= idx_q;
      end
   end

   assign an        = an_q;
   assign seg       = seg_q;
   assign dp        = dp_q;
   assign digit_idx = didx_q;

endmodule

// File: doc/seg_scan_demux.md
SEG_SCAN_DEMUX -- requirements
Module: seg_scan_demux

Parameters
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot; legal range 2 or more.
REQ-002 The block SHALL have parameter BLANK_CYC, default 16, all-anodes-off cycles at the start of each slot; legal range 0 to REFRESH_DIV-1.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit, scan-advance qualifier, from the register-enable select path.
REQ-006 The block SHALL have port digits, input, 16 bits, four hex nibbles; digit i is bits [4i+3:4i].
REQ-007 The block SHALL have port dp_in, input, 4 bits, decimal point request per digit (1 = lit).
REQ-008 The block SHALL have port blank, input, 4 bits, per-digit blank request (1 = digit dark).
REQ-009 The block SHALL have port an, output, 4 bits, active-low anode enables; bit i drives digit i.
REQ-010 The block SHALL have port seg, output, 7 bits, active-low segments {g,f,e,d,c,b,a}, with seg[0]=a.
REQ-011 The block SHALL have port dp, output, 1 bit, active-low decimal point.
REQ-012 The block SHALL have port digit_idx, output, 2 bits, index of the current slot.

Function
REQ-013 The block SHALL hold a slot counter cnt, range 0..REFRESH_DIV-1, and a digit index idx, 2 bits.
REQ-014 When en=1, cnt SHALL increment each cycle; at REFRESH_DIV-1 it SHALL wrap to 0 and idx SHALL advance 0->1->2->3->0.
REQ-015 When en=0, cnt and idx SHALL hold, and an, seg and dp SHALL be all-off (4'hF, 7'h7F, 1) from the next edge.
REQ-016 On any cycle with en=1 and cnt=0, the block SHALL snapshot digits[idx], dp_in[idx] and blank[idx]; mid-slot input changes SHALL NOT alter the displayed slot.
REQ-017 The slot phase SHALL be a two-state FSM: BLANK while cnt<BLANK_CYC, then DRIVE.
REQ-018 In BLANK, the registered outputs SHALL be an=4'hF, seg=7'h7F, dp=1.
REQ-019 In DRIVE, an SHALL be all ones except bit idx=0, seg SHALL be decode(snapshot nibble), and dp SHALL be ~snapshot dp.
REQ-020 If snapshot blank=1 in DRIVE, an SHALL stay 4'hF, seg 7'h7F and dp 1.
REQ-021 Decode SHALL be standard hex with these required values: 0=7'h40, 1=7'h79, 4=7'h19, 8=7'h00, A=7'h08, F=7'h0E; all 16 codes SHALL be defined, with no X output.
REQ-022 an, seg, dp and digit_idx SHALL be registered, with one cycle of latency from the cnt/idx state that selects them.
REQ-023 No output SHALL ever show two anodes low simultaneously.
REQ-024 With BLANK_CYC=0, the block SHALL have no BLANK phase and SHALL drive the new digit on the edge after the wrap.

Reset
REQ-025 While reset_n=0, the block SHALL hold cnt=0, idx=0, an=4'hF, seg=7'h7F, dp=1, digit_idx=0, regardless of clk.
REQ-026 Assertion of reset_n mid-slot SHALL force the reset values immediately; after release the scan SHALL restart at digit 0 with a full BLANK phase.
REQ-027 The first edge after release with en=1 SHALL take the snapshot for digit 0.

Verification (REFRESH_DIV=8, BLANK_CYC=2 unless stated)
REQ-028 Scenario: reset release, en=1, digits=16'hF810, dp_in=0, blank=0 -> 2 cycles an=F; then 6 cycles an=1110/seg=40; 2 blank cycles; then an=1101/seg=79, an=1011/seg=00, an=0111/seg=0E; then wraps to digit 0.
REQ-029 Scenario: change digits[3:0] from 0 to 1 at cnt=4 of slot 0 -> seg stays 40 until slot end; next slot 0 shows 79.
REQ-030 Scenario: en=0 for 5 cycles at cnt=5 of slot 1 -> outputs all-off next edge; on en=1, the slot resumes at cnt=5 with an=1101.
REQ-031 Scenario: blank=4'b0100, dp_in=4'b0001 -> slot 2 an=F, seg=7F; slot 0 dp=0; others dp=1.
REQ-032 Scenario: reset_n pulsed low asynchronously at mid-slot 3 -> outputs reset without clk; after release the scan restarts at digit_idx 0 with 2 blank cycles.
REQ-033 Scenario: BLANK_CYC=0, continuous run -> at most one an bit is low in every cycle; the next anode is driven on the edge after the wrap.
